// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers and RR-stage stall request
module md_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             md_use_rr,
  output logic             stall_req,
  output logic             start,
  output logic             busy,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic [WIDTH-1:0] res_hi, res_lo, q_hi, q_lo;
  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic [WIDTH-1:0] dvd, dvs, dvs_nz, uq, ur, quo, rem;
  logic is_mul, is_div, sdiv, div_zero;
  assign busy      = state == RUN;
  assign is_mul    = op == 4'd1 || op == 4'd2;
  assign is_div    = op == 4'd3 || op == 4'd4;
  assign start     = op_valid & ~busy & (is_mul | is_div);
  assign stall_req = md_use_rr & (start | busy);
  assign rd_data   = op == 4'd7 ? hi : op == 4'd8 ? lo : '0;
  assign prod_s = $signed({{WIDTH{src_a[WIDTH-1]}}, src_a}) * $signed({{WIDTH{src_b[WIDTH-1]}}, src_b});
  assign prod_u = {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b};
  // Signed divide runs on magnitudes so most-negative / -1 falls out naturally as LO=src_a, HI=0
  assign sdiv     = op == 4'd3;
  assign div_zero = src_b == '0;
  assign dvd      = sdiv & src_a[WIDTH-1] ? -src_a : src_a;
  assign dvs      = sdiv & src_b[WIDTH-1] ? -src_b : src_b;
  assign dvs_nz   = div_zero ? WIDTH'(1) : dvs;
  assign uq       = dvd / dvs_nz;
  assign ur       = dvd % dvs_nz;
  assign quo      = sdiv & (src_a[WIDTH-1] ^ src_b[WIDTH-1]) ? -uq : uq;
  assign rem      = sdiv & src_a[WIDTH-1] ? -ur : ur;
  always_comb begin
    q_hi = op == 4'd1 ? prod_s[2*WIDTH-1:WIDTH] : op == 4'd2 ? prod_u[2*WIDTH-1:WIDTH] : div_zero ? src_a : rem;
    q_lo = op == 4'd1 ? prod_s[WIDTH-1:0] : op == 4'd2 ? prod_u[WIDTH-1:0] : div_zero ? '1 : quo;
  end
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = start ? RUN : IDLE;
    else state_nx = cnt == 4'd1 ? IDLE : RUN;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      res_hi <= '0;
      res_lo <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state <= state_nx;
      if (start) begin
        res_hi <= q_hi;
        res_lo <= q_lo;
        cnt    <= is_mul ? 4'(MUL_LAT) : 4'(DIV_LAT);
      end else if (busy) cnt <= cnt - 4'd1;
      if (busy && cnt == 4'd1) begin
        hi <= res_hi;
        lo <= res_lo;
      end
      if (op_valid && !busy && op == 4'd5) hi <= src_a;
      if (op_valid && !busy && op == 4'd6) lo <= src_a;
    end
  end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed vector table plus hand-written corner sequences for md_unit
module tb_md_unit;
  logic        clk = 0, reset = 1, op_valid = 0, md_use_rr = 0;
  logic [3:0]  op = 0;
  logic [31:0] src_a = 0, src_b = 0;
  logic        stall_req, start, busy;
  logic [31:0] rd_data, hi, lo;
  int vecs = 0, errs = 0;

  md_unit #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .src_a(src_a), .src_b(src_b),
    .md_use_rr(md_use_rr), .stall_req(stall_req), .start(start), .busy(busy),
    .rd_data(rd_data), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a, b, hi, lo;
    int          lat;
  } vec_t;
  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input string name, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input int lat);
    int n, st;
    @(negedge clk);
    op_valid = 1; op = o; src_a = a; src_b = b; md_use_rr = 1;
    #1;
    check({name, " start"}, 32'(start), 32'd1);
    st = int'(stall_req);
    @(negedge clk);
    op_valid = 0; op = 0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      st += int'(stall_req);
      @(negedge clk);
    end
    check({name, " busy cycles"}, 32'(n), 32'(lat));
    check({name, " stall cycles"}, 32'(st), 32'(lat + 1));
    check({name, " stall drop"}, 32'(stall_req), 32'd0);
    md_use_rr = 0;
  endtask

  initial begin
    tbl[0]  = '{"multu max*2",   4'd2, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
    tbl[1]  = '{"mult 3*4",      4'd1, 32'd3,        32'd4,        32'h00000000, 32'h0000000C, 5};
    tbl[2]  = '{"mult -1*-1",    4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 5};
    tbl[3]  = '{"mult min*2",    4'd1, 32'h80000000, 32'd2,        32'hFFFFFFFF, 32'h00000000, 5};
    tbl[4]  = '{"multu 2^16^2",  4'd2, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5};
    tbl[5]  = '{"div -7/2",      4'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    tbl[6]  = '{"div 7/-2",      4'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    tbl[7]  = '{"divu x/0",      4'd4, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 10};
    tbl[8]  = '{"div ovf",       4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    tbl[9]  = '{"divu max/2",    4'd4, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'h7FFFFFFF, 10};
    tbl[10] = '{"div 5/0",       4'd3, 32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, 10};

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0; md_use_rr = 1;
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    check("reset stall", 32'(stall_req), 32'd0);
    md_use_rr = 0;

    for (int i = 0; i < 11; i++) begin
      run_op(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].lat);
      check({tbl[i].name, " hi"}, hi, tbl[i].hi);
      check({tbl[i].name, " lo"}, lo, tbl[i].lo);
      op = 8; #1;
      check({tbl[i].name, " mflo"}, rd_data, tbl[i].lo);
      op = 7; #1;
      check({tbl[i].name, " mfhi"}, rd_data, tbl[i].hi);
      op = 0;
    end

    // mtlo and a second mult presented mid-run must both be dropped
    begin
      int n;
      @(negedge clk);
      op_valid = 1; op = 1; src_a = 3; src_b = 4;
      @(negedge clk);
      op = 6; src_a = 32'hAA;
      #1 check("ign mtlo start", 32'(start), 32'd0);
      @(negedge clk);
      op = 1; src_a = 5; src_b = 5;
      #1 check("ign mult start", 32'(start), 32'd0);
      @(negedge clk);
      op_valid = 0; op = 0;
      n = 2;
      while (busy && n < 40) begin
        n++;
        @(negedge clk);
      end
      check("ign busy cycles", 32'(n), 32'd5);
      check("ign lo", lo, 32'd12);
      check("ign hi", hi, 32'd0);
    end

    @(negedge clk);
    op_valid = 1; op = 2; src_a = 32'h10000; src_b = 32'h10000;
    @(negedge clk);
    op_valid = 0; op = 0;
    check("rst busy1", 32'(busy), 32'd1);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("rst busy", 32'(busy), 32'd0);
    check("rst hi", hi, 32'd0);
    check("rst lo", lo, 32'd0);
    repeat (6) @(negedge clk);
    check("rst no commit hi", hi, 32'd0);
    check("rst no commit lo", lo, 32'd0);
    check("rst still idle", 32'(busy), 32'd0);

    @(negedge clk);
    op_valid = 1; op = 6; src_a = 32'h55;
    @(negedge clk);
    op = 5; src_a = 32'hDEADBEEF; md_use_rr = 1;
    #1;
    check("mthi start", 32'(start), 32'd0);
    check("mthi stall", 32'(stall_req), 32'd0);
    @(negedge clk);
    op = 7;
    #1;
    check("mfhi data", rd_data, 32'hDEADBEEF);
    check("mthi lo kept", lo, 32'h55);
    check("mthi busy", 32'(busy), 32'd0);
    check("mfhi stall", 32'(stall_req), 32'd0);
    op = 9; src_a = 1; src_b = 1;
    #1;
    check("op9 start", 32'(start), 32'd0);
    check("op9 rd_data", rd_data, 32'd0);
    @(negedge clk);
    op_valid = 0; op = 0; md_use_rr = 0;
    check("op9 busy", 32'(busy), 32'd0);
    check("op9 hi", hi, 32'hDEADBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
